// File: rtl/hazard_meta_pipe_pkg.sv
// Shared optype encodings and the per-stage hazard metadata record.
package hazard_pkg;
  localparam logic [1:0] OPT_NONE   = 2'b00;
  localparam logic [1:0] OPT_ALU    = 2'b01;
  localparam logic [1:0] OPT_LOAD   = 2'b10;
  localparam logic [1:0] OPT_BRANCH = 2'b11;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [4:0] rs2;
    logic [1:0] optype;
  } stage_t;

  localparam stage_t BUBBLE = '{valid: 1'b0, rd: 5'd0, rs2: 5'd0, optype: OPT_NONE};
endpackage

// File: rtl/hazard_meta_pipe_sat_counter.sv
// Saturating up-counter: steps by one per qualifying cycle, sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (inc && ~&cnt)    cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/hazard_meta_pipe.sv
// Hazard metadata pipeline ID->EXE->MEM->WB with stall/flush/load-use counters
// and a sticky watchdog for front-end stalls that never end.
module hazard_meta_pipe
  import hazard_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int STALL_LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_ID,
  input  logic [1:0]       hazard_optype_ID,
  input  logic [4:0]       rd_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             reg_DE_EN,
  input  logic             reg_DE_flush,
  input  logic             reg_EM_EN,
  input  logic             reg_EM_flush,
  input  logic             reg_MW_EN,
  input  logic             PC_EN_IF,
  input  logic             reg_FD_flush,
  output logic [4:0]       rd_EXE,
  output logic [4:0]       rs2_EXE,
  output logic [1:0]       hazard_optype_ctrl_before1,
  output logic [4:0]       rd_MEM,
  output logic [1:0]       hazard_optype_ctrl_before2,
  output logic [4:0]       rd_WB,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] loaduse_cnt,
  output logic             hang_err
);
  localparam int RUN_W = $clog2(STALL_LIMIT + 1);

  stage_t           r_exe, r_mem, r_wb;
  stage_t           w_id;
  logic [RUN_W-1:0] r_run;
  logic             w_run_hit;
  logic             w_loaduse;

  // An invalid ID slot enters as a clean bubble so rd=0 never aliases a real hazard.
  assign w_id = valid_ID ? '{valid: 1'b1, rd: rd_ID, rs2: rs2_ID, optype: hazard_optype_ID}
                         : BUBBLE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exe <= BUBBLE;
      r_mem <= BUBBLE;
      r_wb  <= BUBBLE;
    end else begin
      if (reg_DE_flush)   r_exe <= BUBBLE;
      else if (reg_DE_EN) r_exe <= w_id;
      if (reg_EM_flush)   r_mem <= BUBBLE;
      else if (reg_EM_EN) r_mem <= r_exe;
      if (reg_MW_EN)      r_wb  <= r_mem;
    end
  end

  assign rd_EXE                     = r_exe.rd;
  assign rs2_EXE                    = r_exe.rs2;
  assign hazard_optype_ctrl_before1 = r_exe.optype;
  assign rd_MEM                     = r_mem.rd;
  assign hazard_optype_ctrl_before2 = r_mem.optype;
  assign rd_WB                      = r_wb.rd;

  assign w_loaduse = ~PC_EN_IF && (r_exe.optype == OPT_LOAD);

  sat_counter #(.W(CNT_W)) u_stall_cnt   (.clk(clk), .rst(rst), .inc(~PC_EN_IF),    .cnt(stall_cnt));
  sat_counter #(.W(CNT_W)) u_flush_cnt   (.clk(clk), .rst(rst), .inc(reg_FD_flush), .cnt(flush_cnt));
  sat_counter #(.W(CNT_W)) u_loaduse_cnt (.clk(clk), .rst(rst), .inc(w_loaduse),    .cnt(loaduse_cnt));

  assign w_run_hit = (r_run == RUN_W'(STALL_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run    <= '0;
      hang_err <= 1'b0;
    end else begin
      if (PC_EN_IF)        r_run <= '0;
      else if (!w_run_hit) r_run <= r_run + RUN_W'(1);
      if (w_run_hit)       hang_err <= 1'b1;
    end
  end

  // Valid bits and downstream rs2/optype are carried for debug visibility only.
  logic w_unused;
  assign w_unused = ^{r_exe.valid, r_mem.valid, r_mem.rs2, r_wb.valid, r_wb.rs2, r_wb.optype};
endmodule
